// File: rtl/sram_pkg.sv
// Shared types and helpers for the byte-enable SRAM controller.
// Holds the FSM state encoding and lane/latency helpers.
package sram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int DWIDTH_DEF = 24;
    localparam int NBYTES     = DWIDTH_DEF / 8;

    function automatic int nbytes(input int dw);
        return dw / 8;
    endfunction

    function automatic bit rd_lat_ok(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage

// File: rtl/sram_be_core.sv
// Raw storage: per-lane write port and registered read port.
// Same-address collisions may forward the merged write word.
module sram_be_core
    import sram_pkg::*;
#(
    parameter int DWIDTH      = 24,
    parameter int AWIDTH      = 6,
    parameter int WRITE_FIRST = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [DWIDTH/8-1:0]   be,
    input  logic [AWIDTH-1:0]     addr_w,
    input  logic [DWIDTH-1:0]     data_w,
    input  logic                  re,
    input  logic [AWIDTH-1:0]     addr_r,
    output logic [DWIDTH-1:0]     rd_data
);

    localparam int NB = nbytes(DWIDTH);

    logic [DWIDTH-1:0] mem [2**AWIDTH];
    logic [DWIDTH-1:0] wr_word;
    logic              fwd;

    // Old word at the write address with enabled lanes replaced
    always_comb begin
        wr_word = mem[addr_w];
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                wr_word[8*i +: 8] = data_w[8*i +: 8];
            end
        end
    end

    assign fwd = (WRITE_FIRST != 0) && we && (addr_w == addr_r);

    // Array write; storage itself is never reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr_w] <= wr_word;
        end
    end

    // Read register, only updated by an accepted read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (re) begin
            rd_data <= fwd ? wr_word : mem[addr_r];
        end
    end

endmodule

// File: rtl/sram_be_ctrl.sv
// Byte-enable SRAM with clear sequencer and valid-tagged reads.
// Latency 1 uses the core read register; latency 2 adds one stage.
module sram_be_ctrl
    import sram_pkg::*;
#(
    parameter int DWIDTH       = 24,
    parameter int AWIDTH       = 6,
    parameter int RD_LAT       = 1,
    parameter int WRITE_FIRST  = 0,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_req,
    output logic                  init_busy,
    input  logic                  we,
    input  logic [DWIDTH/8-1:0]   be,
    input  logic [AWIDTH-1:0]     addr_w,
    input  logic [DWIDTH-1:0]     data_i,
    input  logic                  re,
    input  logic [AWIDTH-1:0]     addr_r,
    output logic [DWIDTH-1:0]     data_o,
    output logic                  rd_valid
);

    localparam int LAT = rd_lat_ok(RD_LAT) ? RD_LAT : 1;
    localparam logic [AWIDTH-1:0] ADDR_LAST = '1;
    localparam state_t ST_RST =
        (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_READY;

    state_t            state, state_nx;
    logic [AWIDTH-1:0] clr_addr, clr_addr_nx;
    logic              busy;
    logic              rd_en;
    logic              core_we;
    logic [DWIDTH/8-1:0] core_be;
    logic [AWIDTH-1:0] core_addr_w;
    logic [DWIDTH-1:0] core_data_w;
    logic [DWIDTH-1:0] core_rd;
    logic              v1;

    assign busy      = (state == ST_CLEAR);
    assign init_busy = busy;
    assign rd_en     = re & ~busy;

    assign core_we     = busy | we;
    assign core_be     = busy ? '1 : be;
    assign core_addr_w = busy ? clr_addr : addr_w;
    assign core_data_w = busy ? '0 : data_i;

    // State and sweep address registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RST;
            clr_addr <= '0;
        end else begin
            state    <= state_nx;
            clr_addr <= clr_addr_nx;
        end
    end

    // Sweep sequencing; a clear request always restarts at word 0
    always_comb begin
        state_nx    = state;
        clr_addr_nx = clr_addr;
        unique case (state)
            ST_CLEAR: begin
                if (clear_req) begin
                    clr_addr_nx = '0;
                end else if (clr_addr == ADDR_LAST) begin
                    state_nx    = ST_READY;
                    clr_addr_nx = '0;
                end else begin
                    clr_addr_nx = clr_addr + 1'b1;
                end
            end
            ST_READY: begin
                if (clear_req) begin
                    state_nx    = ST_CLEAR;
                    clr_addr_nx = '0;
                end
            end
            default: begin
                state_nx    = ST_RST;
                clr_addr_nx = '0;
            end
        endcase
    end

    sram_be_core #(
        .DWIDTH      (DWIDTH),
        .AWIDTH      (AWIDTH),
        .WRITE_FIRST (WRITE_FIRST)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (core_we),
        .be      (core_be),
        .addr_w  (core_addr_w),
        .data_w  (core_data_w),
        .re      (rd_en),
        .addr_r  (addr_r),
        .rd_data (core_rd)
    );

    // First valid stage tracks reads accepted by the core
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
        end else begin
            v1 <= rd_en;
        end
    end

    if (LAT == 2) begin : g_lat2
        logic              v2;
        logic [DWIDTH-1:0] dq;

        // Output stage, loads only when a read emerges
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v2 <= 1'b0;
                dq <= '0;
            end else begin
                v2 <= v1;
                if (v1) begin
                    dq <= core_rd;
                end
            end
        end

        assign rd_valid = v2;
        assign data_o   = dq;
    end else begin : g_lat1
        assign rd_valid = v1;
        assign data_o   = core_rd;
    end

endmodule

// File: tb/tb_sram_be_ctrl.sv
// Randomized bench for sram_be_ctrl with a behavioural reference.
// Two instances: (RD_LAT=1, old-word) and (RD_LAT=2, new-word).
module tb_sram_be_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear_req;
    logic        we;
    logic [2:0]  be;
    logic [5:0]  addr_w;
    logic [23:0] data_i;
    logic        re;
    logic [5:0]  addr_r;

    logic        init_busy_a, init_busy_b;
    logic [23:0] data_o_a, data_o_b;
    logic        rd_valid_a, rd_valid_b;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          due;
        logic [23:0] d;
    } rd_t;

    logic [23:0] mem [64];
    rd_t         qa[$];
    rd_t         qb[$];
    logic [23:0] la, lb;
    bit          m_busy;
    int          m_cnt;
    int          edge_n = 0;

    always #5 clk = ~clk;

    sram_be_ctrl #(
        .DWIDTH(24), .AWIDTH(6), .RD_LAT(1),
        .WRITE_FIRST(0), .CLEAR_ON_RST(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req),
        .init_busy(init_busy_a), .we(we), .be(be),
        .addr_w(addr_w), .data_i(data_i), .re(re),
        .addr_r(addr_r), .data_o(data_o_a),
        .rd_valid(rd_valid_a)
    );

    sram_be_ctrl #(
        .DWIDTH(24), .AWIDTH(6), .RD_LAT(2),
        .WRITE_FIRST(1), .CLEAR_ON_RST(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req),
        .init_busy(init_busy_b), .we(we), .be(be),
        .addr_w(addr_w), .data_i(data_i), .re(re),
        .addr_r(addr_r), .data_o(data_o_b),
        .rd_valid(rd_valid_b)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] merge(input logic [23:0] old,
                                          input logic [23:0] nw,
                                          input logic [2:0]  b);
        logic [23:0] m;
        m = {{8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
        return (old & ~m) | (nw & m);
    endfunction

    // Reference: applies the rules for one clock edge
    task automatic model_edge();
        logic [23:0] va, vb;
        edge_n++;
        if (m_busy) begin
            mem[m_cnt] = '0;
            if (clear_req) m_cnt = 0;
            else if (m_cnt == 63) m_busy = 0;
            else m_cnt++;
        end else begin
            if (re) begin
                va = mem[addr_r];
                vb = (we && addr_w == addr_r) ?
                     merge(mem[addr_w], data_i, be) : va;
                qa.push_back('{edge_n, va});
                qb.push_back('{edge_n + 1, vb});
            end
            if (we) mem[addr_w] = merge(mem[addr_w], data_i, be);
            if (clear_req) begin
                m_busy = 1;
                m_cnt  = 0;
            end
        end
    endtask

    task automatic compare();
        bit  ea, eb;
        rd_t t;
        ea = (qa.size() > 0) && (qa[0].due == edge_n);
        eb = (qb.size() > 0) && (qb[0].due == edge_n);
        if (ea) begin t = qa.pop_front(); la = t.d; end
        if (eb) begin t = qb.pop_front(); lb = t.d; end
        chk("busy_a", 32'(init_busy_a), 32'(m_busy));
        chk("busy_b", 32'(init_busy_b), 32'(m_busy));
        chk("valid_a", 32'(rd_valid_a), 32'(ea));
        chk("valid_b", 32'(rd_valid_b), 32'(eb));
        chk("data_a", 32'(data_o_a), 32'(la));
        chk("data_b", 32'(data_o_b), 32'(lb));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
        @(negedge clk);
    endtask

    task automatic idle();
        clear_req = 0; we = 0; re = 0; be = '0;
        addr_w = '0; addr_r = '0; data_i = '0;
    endtask

    task automatic rand_ops();
        logic [5:0] msk;
        msk       = ($urandom_range(0, 1) == 1) ? 6'h0f : 6'h3f;
        clear_req = 0;
        we        = 1'($urandom_range(0, 1));
        re        = 1'($urandom_range(0, 1));
        be        = 3'($urandom_range(0, 7));
        addr_w    = 6'($urandom_range(0, 63)) & msk;
        addr_r    = 6'($urandom_range(0, 63)) & msk;
        data_i    = 24'($urandom);
    endtask

    task automatic wr(input int a, input logic [23:0] d,
                      input logic [2:0] b);
        idle();
        we = 1; addr_w = 6'(a); data_i = d; be = b;
        step();
        idle();
    endtask

    task automatic rd(input int a);
        idle();
        re = 1; addr_r = 6'(a);
        step();
        idle();
    endtask

    // Counts edges taken with init_busy high; restart pulses at n
    task automatic sweep_count(input int restart_at, output int n);
        n = 0;
        while (init_busy_a && n < 300) begin
            n++;
            rand_ops();
            clear_req = (n == restart_at);
            step();
        end
        idle();
    endtask

    task automatic do_reset();
        #2 rst_n = 0;
        #1;
        chk("rst_data_a", 32'(data_o_a), 32'h0);
        chk("rst_valid_a", 32'(rd_valid_a), 32'h0);
        chk("rst_data_b", 32'(data_o_b), 32'h0);
        chk("rst_valid_b", 32'(rd_valid_b), 32'h0);
        chk("rst_busy", 32'(init_busy_a), 32'h1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        qa.delete();
        qb.delete();
        la = '0; lb = '0;
        m_busy = 1; m_cnt = 0;
    endtask

    task automatic read_all_zero(input string tag);
        int nv;
        nv = 0;
        for (int i = 0; i < 64; i++) begin
            rd(i);
            if (rd_valid_a) begin
                nv++;
                chk(tag, 32'(data_o_a), 32'h0);
            end
        end
        step();
        chk({tag, "_nvalid"}, 32'(nv), 32'd64);
    endtask

    initial begin
        int n, nv;
        idle();
        rst_n = 0;
        foreach (mem[i]) mem[i] = '0;
        la = '0; lb = '0;
        m_busy = 1; m_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;

        chk("t1_busy0", 32'(init_busy_a), 32'h1);
        sweep_count(0, n);
        chk("t1_busy_len", 32'(n), 32'd64);
        read_all_zero("t1_zero");

        wr(5, 24'hABCDEF, 3'b111);
        wr(5, 24'h123456, 3'b010);
        rd(5);
        chk("t2_lat1", 32'(data_o_a), 32'hAB34EF);
        step();
        chk("t2_lat2", 32'(data_o_b), 32'hAB34EF);

        wr(9, 24'h111111, 3'b111);
        we = 1; addr_w = 6'd9; data_i = 24'h222222;
        be = 3'b111; re = 1; addr_r = 6'd9;
        step();
        idle();
        chk("t3_old", 32'(data_o_a), 32'h111111);
        step();
        chk("t3_new", 32'(data_o_b), 32'h222222);
        rd(9);
        chk("t3_after_a", 32'(data_o_a), 32'h222222);
        step();
        chk("t3_after_b", 32'(data_o_b), 32'h222222);

        for (int i = 0; i < 16; i++)
            wr(i, 24'($urandom), 3'b111);
        nv = 0;
        for (int i = 0; i < 16; i++) begin
            re = 1; addr_r = 6'(i);
            step();
            if (rd_valid_a) nv++;
        end
        idle();
        repeat (3) step();
        chk("t4_stream", 32'(nv), 32'd16);
        chk("t4_hold_a", 32'(data_o_a), 32'(mem[15]));
        chk("t4_hold_b", 32'(data_o_b), 32'(mem[15]));

        for (int i = 0; i < 64; i++)
            wr(i, 24'($urandom) | 24'h1, 3'b111);
        re = 1; addr_r = 6'd3;
        step();
        idle();
        clear_req = 1;
        step();
        idle();
        sweep_count(0, n);
        chk("t5_busy_len", 32'(n), 32'd64);
        read_all_zero("t5_zero");
        for (int i = 0; i < 8; i++)
            wr(i, 24'($urandom) | 24'h1, 3'b111);
        clear_req = 1;
        step();
        idle();
        sweep_count(30, n);
        chk("t5_restart_len", 32'(n), 32'd94);

        clear_req = 1;
        step();
        idle();
        repeat (10) step();
        do_reset();
        sweep_count(0, n);
        chk("t6_sweep_rst", 32'(n), 32'd64);
        wr(7, 24'hC0FFEE, 3'b111);
        rd(7);
        chk("t6_pre", 32'(data_o_a), 32'hC0FFEE);
        do_reset();
        step();
        sweep_count(0, n);
        chk("t6_read_rst", 32'(n), 32'd63);

        for (int k = 0; k < 2000; k++) begin
            rand_ops();
            clear_req = ($urandom_range(0, 299) == 0);
            step();
        end
        idle();
        sweep_count(0, n);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
